enc_pb_scan: RTL and testbench



---
 rtl/enc_pb_pkg.sv | 13 +
 rtl/enc_pb_scan_db_filter.sv | 25 ++
 rtl/enc_pb_scan.sv | 102 ++++++++++
 tb/tb_enc_pb_scan.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pb_pkg.sv
// enc_pb_pkg: shared constants, types and quadrature step decode for enc_pb_scan.
package enc_pb_pkg;
    localparam int ENC_NUM = 8;
    localparam int PB_NUM  = 8;
    typedef logic [1:0] quad_t;
    // Gray {B,A} maps to ring position {B, B^A}; the position delta gives the step.
    // Returns {err, dir} with dir as 2-bit signed: +1 = 01, -1 = 11, none = 00.
    function automatic logic [2:0] quad_step(input quad_t prev, input quad_t cur);
        logic [1:0] d;
        d = {cur[1], ^cur} - {prev[1], ^prev};
        return (d == 2'd2) ? 3'b100 : {1'b0, d};
    endfunction
endpackage

// File: rtl/enc_pb_scan_db_filter.sv
// db_filter: one debounced bit; a new level is accepted after DB_LEN equal tick samples.
module db_filter #(
    parameter int DB_LEN = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic tick_i,
    input  logic d_i,
    output logic q_o
);
    logic [DB_LEN-1:0] hist_q, hist_d;
    logic              lvl_q, lvl_d;
    assign hist_d = tick_i ? {hist_q[DB_LEN-2:0], d_i} : hist_q;
    assign lvl_d  = (tick_i && (&hist_d || ~|hist_d)) ? hist_d[0] : lvl_q;
    assign q_o    = lvl_q;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hist_q <= '0;
            lvl_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            lvl_q  <= lvl_d;
        end
    end
endmodule

// File: rtl/enc_pb_scan.sv
// enc_pb_scan: synchronise, debounce and quadrature-decode 8 encoders and 8 pushbuttons.
// Define ENC_DETENT_EN to count one step per full detent cycle instead of per transition.
module enc_pb_scan
    import enc_pb_pkg::*;
#(
    parameter int DB_DIV = 4096,
    parameter int DB_LEN = 4,
    parameter int CNT_W  = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [2*ENC_NUM-1:0]     enc_i,
    input  logic [PB_NUM-1:0]        pb_i,
    input  logic [ENC_NUM-1:0]       clr_i,
    output logic [ENC_NUM*CNT_W-1:0] enc_cnt_o,
    output logic [PB_NUM-1:0]        pb_o,
    output logic [PB_NUM-1:0]        pb_press_o,
    output logic [ENC_NUM-1:0]       enc_err_o
);
    localparam int EW  = 2 * ENC_NUM;
    localparam int NIN = EW + PB_NUM;
    localparam int DW  = $clog2(DB_DIV);
    // Raw buttons idle high, so their synchronisers reset to the released level.
    localparam logic [NIN-1:0] SYNC_RST = {{PB_NUM{1'b1}}, {EW{1'b0}}};

    logic [DW-1:0]     div_q, div_d;
    logic              tick;
    logic [NIN-1:0]    s1_q, s2_q, sync_in, db;
    logic [EW-1:0]     prev_q;
    logic [PB_NUM-1:0] pb_q, press_q;

    assign tick    = div_q == DW'(DB_DIV - 1);
    assign div_d   = tick ? '0 : div_q + DW'(1);
    assign sync_in = {~s2_q[NIN-1:EW], s2_q[EW-1:0]};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            div_q   <= '0;
            s1_q    <= SYNC_RST;
            s2_q    <= SYNC_RST;
            prev_q  <= '0;
            pb_q    <= '0;
            press_q <= '0;
        end else begin
            div_q   <= div_d;
            s1_q    <= {pb_i, enc_i};
            s2_q    <= s1_q;
            prev_q  <= db[EW-1:0];
            pb_q    <= db[NIN-1:EW];
            press_q <= db[NIN-1:EW] & ~pb_q;
        end
    end

    assign pb_o       = pb_q;
    assign pb_press_o = press_q;

    for (genvar i = 0; i < NIN; i++) begin : g_db
        db_filter #(.DB_LEN(DB_LEN)) u_db (
            .clk_i  (clk_i),
            .rstn_i (rstn_i),
            .tick_i (tick),
            .d_i    (sync_in[i]),
            .q_o    (db[i])
        );
    end

    for (genvar n = 0; n < ENC_NUM; n++) begin : g_enc
        quad_t                   cur, prev;
        logic                    err, err_q, err_d;
        logic signed [1:0]       dir;
        logic signed [CNT_W-1:0] cnt_q, cnt_d, step;
        assign cur          = db[2*n +: 2];
        assign prev         = prev_q[2*n +: 2];
        assign {err, dir}   = quad_step(prev, cur);
`ifdef ENC_DETENT_EN
        // Any return to 00 closes the detent; only a full +-4 excursion counts.
        logic signed [3:0] sub_q, sub_d, sub_n;
        assign sub_n = (clr_i[n] ? 4'sd0 : sub_q) + {{2{dir[1]}}, dir};
        assign sub_d = (cur == 2'b00) ? 4'sd0 : sub_n;
        assign step  = (cur != 2'b00) ? '0 : (sub_n == 4'sd4) ? CNT_W'(1) : (sub_n == -4'sd4) ? '1 : '0;
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) sub_q <= '0;
            else sub_q <= sub_d;
        end
`else
        assign step = {{(CNT_W-2){dir[1]}}, dir};
`endif
        assign cnt_d = (clr_i[n] ? '0 : cnt_q) + step;
        assign err_d = err | (err_q & ~clr_i[n]);
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                cnt_q <= '0;
                err_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                err_q <= err_d;
            end
        end
        assign enc_cnt_o[CNT_W*n +: CNT_W] = cnt_q;
        assign enc_err_o[n]                = err_q;
    end
endmodule

// File: tb/tb_enc_pb_scan.sv
// tb_enc_pb_scan: directed plus randomized bench for enc_pb_scan against a position/level model.
module tb_enc_pb_scan;
    localparam int DB_DIV = 4;
    localparam int DB_LEN = 3;
    localparam int CNT_W  = 8;
    localparam int HOLD   = 20;

    logic        clk_i  = 1'b0;
    logic        rstn_i = 1'b0;
    logic [15:0] enc_i  = '0;
    logic [7:0]  pb_i   = '1;
    logic [7:0]  clr_i  = '0;
    logic [63:0] enc_cnt_o;
    logic [7:0]  pb_o, pb_press_o, enc_err_o;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          press_cnt [8];
    int          exp_press [8];
    int          m_pos [8];
    int          m_sub [8];
    logic [7:0]  m_cnt [8];
    logic [7:0]  m_err = '0;
    logic [7:0]  m_pb  = '0;
    logic [1:0]  gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [7:0]  pb_prev = '0;
    logic        rst_prev = 1'b0;

    enc_pb_scan #(.DB_DIV(DB_DIV), .DB_LEN(DB_LEN), .CNT_W(CNT_W)) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .enc_i      (enc_i),
        .pb_i       (pb_i),
        .clr_i      (clr_i),
        .enc_cnt_o  (enc_cnt_o),
        .pb_o       (pb_o),
        .pb_press_o (pb_press_o),
        .enc_err_o  (enc_err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= rstn_i ? cyc + 1 : 0;

    // A press pulse must coincide exactly with each 0->1 edge of the debounced level.
    always @(negedge clk_i) begin
        if (rstn_i && rst_prev) begin
            checks++;
            assert (pb_press_o === (pb_o & ~pb_prev)) else begin
                errors++;
                $error("FAIL press_edge got %h exp %h", pb_press_o, pb_o & ~pb_prev);
            end
        end
        for (int b = 0; b < 8; b++) press_cnt[b] += int'(pb_press_o[b]);
        pb_prev  = pb_o;
        rst_prev = rstn_i;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_vec();
        logic [63:0] v;
        for (int n = 0; n < 8; n++) v[8*n +: 8] = m_cnt[n];
        return v;
    endfunction

    task automatic move(input int e, input int d);
        m_pos[e] = (m_pos[e] + d) & 3;
        enc_i[2*e +: 2] = gray[m_pos[e]];
        if (d == 2 || d == -2) m_err[e] = 1'b1;
`ifdef ENC_DETENT_EN
        else begin
            m_sub[e] += d;
            if (m_pos[e] == 0) begin
                if (m_sub[e] == 4) m_cnt[e] += 8'd1;
                else if (m_sub[e] == -4) m_cnt[e] -= 8'd1;
                m_sub[e] = 0;
            end
        end
`else
        else m_cnt[e] += 8'(d);
`endif
    endtask

    task automatic settle();
        repeat (HOLD) @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic step(input int e, input int d);
        @(posedge clk_i); #1;
        move(e, d);
        settle();
    endtask

    task automatic clear(input int e);
        @(posedge clk_i); #1;
        clr_i[e] = 1'b1;
        m_cnt[e] = '0;
        m_err[e] = 1'b0;
        m_sub[e] = 0;
        @(posedge clk_i); #1;
        clr_i = '0;
        settle();
    endtask

    task automatic align();
        do begin
            @(posedge clk_i); #1;
        end while (cyc % 4 != 0);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_cnt"}, enc_cnt_o, m_vec());
        chk({tag, "_err"}, 64'(enc_err_o), 64'(m_err));
        chk({tag, "_pb"}, 64'(pb_o), 64'(m_pb));
    endtask

    task automatic chk_press(input string tag);
        for (int b = 0; b < 8; b++) chk($sformatf("%s_press%0d", tag, b), 64'(press_cnt[b]), 64'(exp_press[b]));
    endtask

    initial begin
        int lat;
        int e, r, d;
        logic [7:0] old;
        for (int n = 0; n < 8; n++) begin
            m_cnt[n] = '0; m_pos[n] = 0; m_sub[n] = 0; press_cnt[n] = 0; exp_press[n] = 0;
        end
        // Reset held while inputs toggle.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i); #1;
            enc_i = 16'($urandom); pb_i = 8'($urandom); clr_i = 8'($urandom);
            @(negedge clk_i);
            chk("rst_cnt", enc_cnt_o, 64'h0);
            chk("rst_outs", {pb_o, pb_press_o, enc_err_o}, 64'h0);
        end
        @(posedge clk_i); #1;
        enc_i = '0; pb_i = '0; clr_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        @(negedge clk_i);
        chk("rel_pb", 64'(pb_o), 64'h0);
        m_pb = 8'hFF;
        for (int b = 0; b < 8; b++) exp_press[b] = 1;
        settle();
        chk_all("rel");
        chk_press("rel");
        // Release all buttons: no pulses on release.
        @(posedge clk_i); #1;
        pb_i = '1; m_pb = '0;
        settle();
        chk_all("rls");
        chk_press("rls");
        // Glitch of 2 ticks must not pass; 4 ticks must.
        @(posedge clk_i); #1;
        pb_i[3] = 1'b0;
        repeat (2 * DB_DIV) @(posedge clk_i);
        #1 pb_i[3] = 1'b1;
        settle();
        chk_all("glitch");
        chk_press("glitch");
        @(posedge clk_i); #1;
        pb_i[3] = 1'b0; m_pb[3] = 1'b1; exp_press[3]++;
        settle();
        chk_all("press4");
        chk_press("press4");
        @(posedge clk_i); #1;
        pb_i[3] = 1'b1; m_pb[3] = 1'b0;
        settle();
        // Count up/down on encoder 2.
        for (int i = 0; i < 10; i++) step(2, 1);
        chk_all("up10");
        for (int i = 0; i < 13; i++) step(2, -1);
        chk_all("dn13");
`ifndef ENC_DETENT_EN
        chk("up_dn_const", 64'(enc_cnt_o[23:16]), 64'hFD);
`endif
        // Wrap on encoder 0.
        for (int i = 0; i < 127; i++) step(0, 1);
        chk_all("pre127");
        step(0, 1);
        chk_all("wrap_up");
`ifndef ENC_DETENT_EN
        chk("wrap_up_const", 64'(enc_cnt_o[7:0]), 64'h80);
`endif
        step(0, -1);
        chk_all("wrap_dn");
`ifndef ENC_DETENT_EN
        chk("wrap_dn_const", 64'(enc_cnt_o[7:0]), 64'h7F);
`endif
        // Illegal jump on encoder 5.
        step(5, 2);
        chk_all("illegal");
        chk("illegal_flag", 64'(enc_err_o[5]), 64'h1);
`ifndef ENC_DETENT_EN
        // Measure input-to-count latency at a fixed divider phase, then land clr on the step cycle.
        align();
        old = enc_cnt_o[55:48];
        move(6, 1);
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(posedge clk_i); #1;
            if (enc_cnt_o[55:48] !== old) lat = i;
        end
        checks++;
        assert (lat != 0) else begin
            errors++;
            $error("FAIL latency_timeout got %0d exp nonzero", lat);
        end
        settle();
        chk_all("lat");
        if (lat > 1) begin
            align();
            move(5, 1);
            m_cnt[5] = 8'd1; m_err[5] = 1'b0;
            repeat (lat - 1) begin
                @(posedge clk_i); #1;
            end
            clr_i[5] = 1'b1;
            @(posedge clk_i); #1;
            clr_i = '0;
            settle();
            chk_all("clr_step");
            chk("clr_step_const", {enc_cnt_o[47:40], 7'b0, enc_err_o[5]}, 16'h0100);
        end
`else
        step(7, 1); step(7, 1); step(7, 1); step(7, 1);
        chk("detent4", 64'(enc_cnt_o[63:56]), 64'h1);
        step(7, 1); step(7, 1); step(7, 1);
        step(7, -1); step(7, -1); step(7, -1);
        chk("detent_rev", 64'(enc_cnt_o[63:56]), 64'h1);
        chk_all("detent");
`endif
        clear(2);
        chk_all("clr_alone");
        // Randomized walk across all encoders and buttons.
        for (int it = 0; it < 60; it++) begin
            e = int'($urandom_range(0, 7));
            r = int'($urandom_range(0, 9));
`ifdef ENC_DETENT_EN
            d = (r < 4) ? -1 : 1;
`else
            d = (r == 0) ? 2 : (r < 5) ? -1 : 1;
`endif
            @(posedge clk_i); #1;
            move(e, d);
            if ($urandom_range(0, 3) == 0) begin
                r = int'($urandom_range(0, 7));
                pb_i[r] = ~pb_i[r];
                m_pb[r] = ~pb_i[r];
                if (m_pb[r]) exp_press[r]++;
            end
            settle();
            if ($urandom_range(0, 5) == 0) clear(int'($urandom_range(0, 7)));
            chk_all($sformatf("rnd%0d", it));
        end
        chk_press("rnd");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
